// File: rtl/morra_pkg.sv
// Shared types and constants for the Morra Cinese match tracker.
//   manche_t : round result code, reused as the match result code
//   state_t  : tracker FSM states
//   MIN_MANCHE, LEAD_WIN, MAX_OFFSET : match decision constants
package morra_pkg;

    typedef enum logic [1:0] {
        M_NONE = 2'b00,
        M_P1   = 2'b01,
        M_P2   = 2'b10,
        M_DRAW = 2'b11
    } manche_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Rounds that must be played before a lead can end the match early.
    localparam int MIN_MANCHE = 4;
    // Round-win lead that ends the match early.
    localparam int LEAD_WIN   = 2;
    // Added to the 4-bit configuration code to form the round limit.
    localparam int MAX_OFFSET = 4;

endpackage

// File: rtl/morra_match_judge.sv
// Combinational match judge.
// Looks at the post-update round count and scores and decides whether the
// match ends on this round, and with which result.
// Ports:
//   cnt_i    : round count including the current round
//   s1_i     : player 1 score including the current round
//   s2_i     : player 2 score including the current round
//   limit_i  : configured round limit
//   decide_o : match ends on this round
//   result_o : match result when decide_o is high (M_NONE otherwise)
module morra_match_judge
    import morra_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] s1_i,
    input  logic [CNT_W-1:0] s2_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             decide_o,
    output manche_t          result_o
);

    logic signed [CNT_W:0] diff;
    logic        [CNT_W:0] mag;
    logic                  lead_ok;
    logic                  at_limit;

    always_comb begin
        // One extra bit keeps the difference signed without overflow.
        diff     = $signed({1'b0, s1_i}) - $signed({1'b0, s2_i});
        mag      = diff[CNT_W] ? (CNT_W+1)'(-diff) : (CNT_W+1)'(diff);
        lead_ok  = (cnt_i >= CNT_W'(MIN_MANCHE)) && (mag >= (CNT_W+1)'(LEAD_WIN));
        at_limit = (cnt_i == limit_i);

        decide_o = lead_ok || at_limit;
        result_o = M_NONE;
        if (lead_ok) begin
            result_o = diff[CNT_W] ? M_P2 : M_P1;
        end else if (at_limit) begin
            if (diff == '0) begin
                result_o = M_DRAW;
            end else if (diff[CNT_W]) begin
                result_o = M_P2;
            end else begin
                result_o = M_P1;
            end
        end
    end

endmodule

// File: rtl/morra_partita_tracker.sv
// Morra Cinese match tracker.
// Counts rounds and round wins from the per-round result strobe and decides
// the match result under the round limit captured from the configuration.
// Optional feature: define MORRA_MATCH_TALLY_EN to add per-player match-win
// counters (partite_p1 / partite_p2), cleared only by reset.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   cfg_valid     : load new match configuration and start a match
//   cfg_max       : round-limit code, limit = cfg_max + MAX_OFFSET
//   manche_valid  : round result strobe
//   manche        : round result code
//   partita       : match result (held until next configuration)
//   partita_valid : one-cycle pulse on the deciding edge
//   busy          : match in progress
//   manche_count  : rounds counted in current match
//   score_p1/p2   : rounds won per player in current match
//   partite_p1/p2 : matches won per player (tally build only)
//
// state | meaning
// IDLE  | no match configured, rounds ignored
// PLAY  | match in progress, counting rounds
// DONE  | match decided, result held, rounds ignored
module morra_partita_tracker
    import morra_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_max,
    input  logic             manche_valid,
    input  logic [1:0]       manche,
    output logic [1:0]       partita,
    output logic             partita_valid,
    output logic             busy,
    output logic [CNT_W-1:0] manche_count,
    output logic [CNT_W-1:0] score_p1,
    output logic [CNT_W-1:0] score_p2
`ifdef MORRA_MATCH_TALLY_EN
    ,
    output logic [CNT_W-1:0] partite_p1,
    output logic [CNT_W-1:0] partite_p2
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] s1_q, s1_d;
    logic [CNT_W-1:0] s2_q, s2_d;
    manche_t          partita_q, partita_d;
    logic             pvalid_q, pvalid_d;

    logic [CNT_W-1:0] count_nxt, s1_nxt, s2_nxt;
    logic             round_ok;
    logic             decide;
    manche_t          result;

    // Candidate post-round values; only committed when a round is counted.
    always_comb begin
        round_ok  = manche_valid && (manche != M_NONE);
        count_nxt = count_q + CNT_W'(1);
        s1_nxt    = (manche == M_P1) ? s1_q + CNT_W'(1) : s1_q;
        s2_nxt    = (manche == M_P2) ? s2_q + CNT_W'(1) : s2_q;
    end

    morra_match_judge #(
        .CNT_W (CNT_W)
    ) u_judge (
        .cnt_i    (count_nxt),
        .s1_i     (s1_nxt),
        .s2_i     (s2_nxt),
        .limit_i  (limit_q),
        .decide_o (decide),
        .result_o (result)
    );

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        count_d   = count_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        partita_d = partita_q;
        pvalid_d  = 1'b0;

        // Configuration wins over any round strobe in the same cycle.
        if (cfg_valid) begin
            limit_d   = CNT_W'(cfg_max) + CNT_W'(MAX_OFFSET);
            count_d   = '0;
            s1_d      = '0;
            s2_d      = '0;
            partita_d = M_NONE;
            state_d   = PLAY;
        end else begin
            case (state_q)
                PLAY: begin
                    if (round_ok) begin
                        count_d = count_nxt;
                        s1_d    = s1_nxt;
                        s2_d    = s2_nxt;
                        if (decide) begin
                            partita_d = result;
                            pvalid_d  = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            limit_q   <= CNT_W'(MAX_OFFSET);
            count_q   <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            partita_q <= M_NONE;
            pvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            partita_q <= partita_d;
            pvalid_q  <= pvalid_d;
        end
    end

    assign partita       = partita_q;
    assign partita_valid = pvalid_q;
    assign busy          = (state_q == PLAY);
    assign manche_count  = count_q;
    assign score_p1      = s1_q;
    assign score_p2      = s2_q;

`ifdef MORRA_MATCH_TALLY_EN
    logic [CNT_W-1:0] tally1_q, tally1_d;
    logic [CNT_W-1:0] tally2_q, tally2_d;

    // Tallies advance on the same edge that raises partita_valid.
    always_comb begin
        tally1_d = tally1_q;
        tally2_d = tally2_q;
        if (pvalid_d && (partita_d == M_P1) && (tally1_q != '1)) begin
            tally1_d = tally1_q + CNT_W'(1);
        end
        if (pvalid_d && (partita_d == M_P2) && (tally2_q != '1)) begin
            tally2_d = tally2_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tally1_q <= '0;
            tally2_q <= '0;
        end else begin
            tally1_q <= tally1_d;
            tally2_q <= tally2_d;
        end
    end

    assign partite_p1 = tally1_q;
    assign partite_p2 = tally2_q;
`endif

endmodule
